// File: rtl/color_pkg.sv
// Shared types and defaults for the colour-sensor frequency generator.
package color_pkg;

    typedef enum logic [1:0] {
        CH_OFF  = 2'd0,
        CH_HIGH = 2'd1,
        CH_LOW  = 2'd2
    } ch_state_e;

    localparam int GREEN_IDX      = 1;
    localparam int CLEAR_IDX      = 0;
    localparam int CNT_W_DEF      = 32;
    localparam int GREEN_HALF_DEF = 50;
    localparam int CLEAR_HALF_DEF = 75;

endpackage

// File: rtl/freq_chan.sv
// One square-wave channel: OFF/HIGH/LOW FSM with shadowed half-period.
module freq_chan
    import color_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int HALF_RST = GREEN_HALF_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_i,
    input  logic             wr_i,
    input  logic [CNT_W-1:0] half_i,
    output logic             wave_o,
    output logic             pend_o,
    output logic             rise_o
);

    localparam logic [CNT_W-1:0] HALF_RST_C = CNT_W'(HALF_RST);

    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] active_q, active_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             pend_q, pend_d;
    logic             wave_q, wave_d;

    logic [CNT_W-1:0] half_nxt;
    logic             at_end;

    assign half_nxt = pend_q ? shadow_q : active_q;
    assign at_end   = (cnt_q == active_q - CNT_W'(1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;
        wave_d   = wave_q;
        if (!enable_i) begin
            state_d  = CH_OFF;
            wave_d   = 1'b0;
            cnt_d    = '0;
            active_d = half_nxt;
            pend_d   = 1'b0;
        end else begin
            unique case (state_q)
                CH_OFF: begin
                    active_d = half_nxt;
                    pend_d   = 1'b0;
                    if (half_nxt != '0) begin
                        state_d = CH_HIGH;
                        wave_d  = 1'b1;
                        cnt_d   = '0;
                    end
                end
                CH_HIGH: begin
                    if (at_end) begin
                        state_d = CH_LOW;
                        wave_d  = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                CH_LOW: begin
                    if (at_end) begin
                        // period boundary: the only safe point to swap halves
                        active_d = half_nxt;
                        pend_d   = 1'b0;
                        cnt_d    = '0;
                        if (half_nxt != '0) begin
                            state_d = CH_HIGH;
                            wave_d  = 1'b1;
                        end else begin
                            state_d = CH_OFF;
                            wave_d  = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = CH_OFF;
                    wave_d  = 1'b0;
                    cnt_d   = '0;
                end
            endcase
        end
        if (wr_i) begin
            shadow_d = half_i;
            pend_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= CH_OFF;
            cnt_q    <= '0;
            active_q <= HALF_RST_C;
            shadow_q <= '0;
            pend_q   <= 1'b0;
            wave_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            wave_q   <= wave_d;
        end
    end

    assign wave_o = wave_q;
    assign pend_o = pend_q;
    assign rise_o = (state_q != CH_HIGH) && (state_d == CH_HIGH);

endmodule

// File: rtl/color_freq_gen.sv
// Dual-channel green/clear square-wave source with valid/ready period loading.
module color_freq_gen
    import color_pkg::*;
#(
    parameter int CNT_W          = CNT_W_DEF,
    parameter int GREEN_HALF_RST = GREEN_HALF_DEF,
    parameter int CLEAR_HALF_RST = CLEAR_HALF_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             load,
    output logic             ready,
    input  logic [CNT_W-1:0] green_half,
    input  logic [CNT_W-1:0] clear_half,
    output logic [1:0]       sensor_freq,
    output logic [15:0]      green_edges
);

    logic        ready_q, ready_d;
    logic [15:0] edges_q, edges_d;
    logic        xfer;
    logic        g_wave, g_pend, g_rise;
    logic        c_wave, c_pend, c_rise;

    assign xfer = load && ready_q;

    freq_chan #(
        .CNT_W    (CNT_W),
        .HALF_RST (GREEN_HALF_RST)
    ) u_green (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable_i (enable),
        .wr_i     (xfer),
        .half_i   (green_half),
        .wave_o   (g_wave),
        .pend_o   (g_pend),
        .rise_o   (g_rise)
    );

    freq_chan #(
        .CNT_W    (CNT_W),
        .HALF_RST (CLEAR_HALF_RST)
    ) u_clear (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable_i (enable),
        .wr_i     (xfer),
        .half_i   (clear_half),
        .wave_o   (c_wave),
        .pend_o   (c_pend),
        .rise_o   (c_rise)
    );

    always_comb begin
        ready_d = ready_q;
        edges_d = edges_q;
        if (xfer) begin
            ready_d = 1'b0;
        end else if (!ready_q && !g_pend && !c_pend) begin
            ready_d = 1'b1;
        end
        if (g_rise) begin
            edges_d = edges_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b1;
            edges_q <= '0;
        end else begin
            ready_q <= ready_d;
            edges_q <= edges_d;
        end
    end

    assign ready                  = ready_q;
    assign green_edges            = edges_q;
    assign sensor_freq[GREEN_IDX] = g_wave;
    assign sensor_freq[CLEAR_IDX] = c_wave;

endmodule

// File: tb/tb_color_freq_gen.sv
// Directed bench for color_freq_gen: periods, handshake, disable and reset.
module tb_color_freq_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        load;
    logic        ready;
    logic [31:0] green_half;
    logic [31:0] clear_half;
    logic [1:0]  sensor_freq;
    logic [15:0] green_edges;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int g_r[$];
    int c_r[$];
    int g_w[$];
    int c_w[$];
    logic pg = 1'b0;
    logic pc = 1'b0;

    always #5 clk = ~clk;

    color_freq_gen dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .load        (load),
        .ready       (ready),
        .green_half  (green_half),
        .clear_half  (clear_half),
        .sensor_freq (sensor_freq),
        .green_edges (green_edges)
    );

    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (sensor_freq[1] && !pg) g_r.push_back(cyc);
        if (!sensor_freq[1] && pg && g_r.size() > 0) g_w.push_back(cyc - g_r[$]);
        if (sensor_freq[0] && !pc) c_r.push_back(cyc);
        if (!sensor_freq[0] && pc && c_r.size() > 0) c_w.push_back(cyc - c_r[$]);
        pg = sensor_freq[1];
        pc = sensor_freq[0];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_ready(input string tag, input int max);
        for (int i = 0; i < max; i++) begin
            if (ready) break;
            @(negedge clk);
        end
        chk(tag, ready, 1);
    endtask

    task automatic wait_green(input logic lvl, input string tag, input int max);
        for (int i = 0; i < max; i++) begin
            if (sensor_freq[1] == lvl) break;
            @(negedge clk);
        end
        chk(tag, sensor_freq[1], lvl);
    endtask

    task automatic do_load(input int g, input int c);
        load       = 1'b1;
        green_half = g;
        clear_half = c;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        int c0, ge0, ng, nc, bad, n0, n1;
        rst_n = 1'b0;
        enable = 1'b0;
        load = 1'b0;
        green_half = '0;
        clear_half = '0;
        idle(3);
        chk("rst_freq", sensor_freq, 0);
        chk("rst_ready", ready, 1);
        chk("rst_edges", green_edges, 0);
        rst_n = 1'b1;
        idle(3);
        chk("dis_freq", sensor_freq, 0);

        // default periods
        enable = 1'b1;
        c0 = cyc;
        @(negedge clk);
        chk("first_rise", sensor_freq, 2'b11);
        idle(320);
        chk("g_first", g_r[0], c0 + 1);
        chk("c_first", c_r[0], c0 + 1);
        chk("g_per100", g_r[1] - g_r[0], 100);
        chk("c_per150", c_r[1] - c_r[0], 150);
        chk("g_hi50", g_w[0], 50);
        chk("c_hi75", c_w[0], 75);
        chk("def_ready", ready, 1);

        // load 5/7 while running
        ng = g_w.size();
        nc = c_w.size();
        do_load(5, 7);
        chk("ld_ready0", ready, 0);
        wait_ready("ld_ready1", 400);
        idle(60);
        chk("g_per10", g_r[$] - g_r[$-1], 10);
        chk("c_per14", c_r[$] - c_r[$-1], 14);
        chk("g_hi5", g_w[$], 5);
        chk("c_hi7", c_w[$], 7);
        bad = 0;
        for (int i = ng; i < g_w.size(); i++)
            if (g_w[i] != 50 && g_w[i] != 5) bad++;
        for (int i = nc; i < c_w.size(); i++)
            if (c_w[i] != 75 && c_w[i] != 7) bad++;
        chk("no_short", bad, 0);

        // green/clear ratio window
        do_load(50, 75);
        wait_ready("ratio_ready", 400);
        c0 = cyc;
        ge0 = green_edges;
        ng = g_r.size();
        nc = c_r.size();
        idle(10000);
        chk("ratio_g", g_r.size() - ng, 100);
        chk("ratio_c", ((c_r.size() - nc) == 66) || ((c_r.size() - nc) == 67), 1);
        chk("ratio_edges", 16'(green_edges - 16'(ge0)), 100);
        chk("ratio_win", cyc - c0, 10000);

        // zero and minimum halves
        do_load(1, 0);
        wait_ready("zm_ready", 400);
        idle(5);
        nc = c_r.size();
        idle(60);
        chk("c_zero_nr", c_r.size(), nc);
        chk("c_zero_lvl", sensor_freq[0], 0);
        chk("g_per2", g_r[$] - g_r[$-1], 2);
        chk("g_hi1", g_w[$], 1);

        // backpressure: second load while ready=0 is dropped
        chk("bp_ready1", ready, 1);
        load = 1'b1;
        green_half = 3;
        clear_half = 4;
        @(negedge clk);
        chk("bp_ready0", ready, 0);
        green_half = 9;
        clear_half = 9;
        @(negedge clk);
        load = 1'b0;
        wait_ready("bp_ready2", 20);
        idle(40);
        chk("bp_g_per6", g_r[$] - g_r[$-1], 6);
        chk("bp_c_per8", c_r[$] - c_r[$-1], 8);

        // enable dropped mid-HIGH with a pending load
        wait_green(1'b0, "en_wlow", 20);
        wait_green(1'b1, "en_whigh", 20);
        chk("en_ready1", ready, 1);
        load = 1'b1;
        green_half = 20;
        clear_half = 30;
        @(negedge clk);
        chk("en_ready0", ready, 0);
        chk("en_midhigh", sensor_freq[1], 1);
        enable = 1'b0;
        load = 1'b0;
        @(negedge clk);
        chk("en_off", sensor_freq, 0);
        @(negedge clk);
        chk("en_ready2", ready, 1);
        enable = 1'b1;
        c0 = cyc;
        n0 = g_r.size();
        n1 = c_r.size();
        idle(200);
        chk("en_g_first", g_r[n0], c0 + 1);
        chk("en_g_per40", g_r[n0+1] - g_r[n0], 40);
        chk("en_c_per60", c_r[n1+1] - c_r[n1], 60);

        // async reset mid-LOW with a pending load
        wait_green(1'b1, "rs_whigh", 50);
        wait_green(1'b0, "rs_wlow", 50);
        do_load(7, 7);
        chk("rs_ready0", ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs_freq", sensor_freq, 0);
        chk("rs_ready", ready, 1);
        chk("rs_edges", green_edges, 0);
        @(negedge clk);
        rst_n = 1'b1;
        c0 = cyc;
        n0 = g_r.size();
        n1 = c_r.size();
        idle(320);
        chk("rs_g_first", g_r[n0], c0 + 1);
        chk("rs_g_per", g_r[n0+1] - g_r[n0], 100);
        chk("rs_c_per", c_r[n1+1] - c_r[n1], 150);
        chk("rs_g_hi", g_w[$], 50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
